// File: rtl/mac_array_tiled.sv
// Tiled matrix-multiply engine: O = W x I, producing LANES outputs per tile and
// writing one packed O word per (row, tile).
//   state   | meaning
//   S_IDLE  | wait for START, validate and latch job
//   S_RUN   | issue one W/I read per n
//   S_DRAIN | accumulate the last read, no new reads
//   S_WRITE | write the finished tile to O
//   S_DONE  | one-cycle completion pulse
module mac_array_tiled #(
  parameter int DW      = 16,
  parameter int LANES   = 4,
  parameter int MAX_DIM = 8,
  parameter int DIM_W   = 4,
  parameter int AW      = 4,
  parameter int ACC_W   = 35
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [3*DIM_W-1:0]    MNT,
  input  logic                  SIGNED,
  input  logic                  SAT,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic                  EN_I,
  output logic [AW-1:0]         ADDR_I,
  input  logic [LANES*DW-1:0]   RDATA_I,
  output logic                  EN_W,
  output logic [AW-1:0]         ADDR_W,
  input  logic [LANES*DW-1:0]   RDATA_W,
  output logic                  EN_O,
  output logic                  RW_O,
  output logic [AW-1:0]         ADDR_O,
  output logic [LANES*DW-1:0]   WDATA_O,
  input  logic [LANES*DW-1:0]   RDATA_O
);
  localparam int TB_MAX = MAX_DIM / LANES;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;
  state_t state_q, state_d;

  logic [DIM_W-1:0] m_dim_q, m_dim_d, n_dim_q, n_dim_d, t_dim_q, t_dim_d;
  logic             sgn_q, sgn_d, sat_q, sat_d;
  logic [DIM_W-1:0] m_q, m_d, tb_q, tb_d, n_q, n_d;
  logic             mac_vld_q, mac_vld_d;
  logic [DIM_W-1:0] mac_n_q, mac_n_d;
  logic             err_q, err_d;
  logic [ACC_W-1:0] acc_q [LANES];
  logic [ACC_W-1:0] acc_d [LANES];

  logic [DIM_W-1:0] req_m, req_n, req_t, tb_cnt;
  logic             start_ok, last_n, last_tb, last_m;
  logic [DW-1:0]    w_sel;
  logic [DW-1:0]    i_el [LANES];
  logic signed [2*DW-1:0] prod_s [LANES];
  logic [2*DW-1:0]  prod_u [LANES];
  logic [ACC_W-1:0] prod [LANES];
  logic [LANES*DW-1:0] wdata;
  logic             unused_rdata_o;

  assign unused_rdata_o = ^RDATA_O;

  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (int'(d) <= MAX_DIM);
  endfunction

  // Signed range holds iff bits [ACC_W-1:DW-1] are all equal.
  function automatic logic [DW-1:0] sat_fn(input logic [ACC_W-1:0] a, input logic sg, input logic st);
    if (!st) return a[DW-1:0];
    if (sg) begin
      if (!a[ACC_W-1] && (a[ACC_W-2:DW-1] != '0)) return {1'b0, {(DW-1){1'b1}}};
      if (a[ACC_W-1] && (a[ACC_W-2:DW-1] != '1)) return {1'b1, {(DW-1){1'b0}}};
      return a[DW-1:0];
    end
    if (a[ACC_W-1:DW] != '0) return '1;
    return a[DW-1:0];
  endfunction

  assign req_m    = MNT[3*DIM_W-1 -: DIM_W];
  assign req_n    = MNT[2*DIM_W-1 -: DIM_W];
  assign req_t    = MNT[DIM_W-1:0];
  assign start_ok = dim_ok(req_m) && dim_ok(req_n) && dim_ok(req_t);
  assign tb_cnt   = DIM_W'((int'(t_dim_q) + LANES - 1) / LANES);
  assign last_n   = (n_q == n_dim_q - DIM_W'(1));
  assign last_tb  = (tb_q == tb_cnt - DIM_W'(1));
  assign last_m   = (m_q == m_dim_q - DIM_W'(1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_IDLE;
      m_dim_q   <= '0;
      n_dim_q   <= '0;
      t_dim_q   <= '0;
      sgn_q     <= 1'b0;
      sat_q     <= 1'b0;
      m_q       <= '0;
      tb_q      <= '0;
      n_q       <= '0;
      mac_vld_q <= 1'b0;
      mac_n_q   <= '0;
      err_q     <= 1'b0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
    end else begin
      state_q   <= state_d;
      m_dim_q   <= m_dim_d;
      n_dim_q   <= n_dim_d;
      t_dim_q   <= t_dim_d;
      sgn_q     <= sgn_d;
      sat_q     <= sat_d;
      m_q       <= m_d;
      tb_q      <= tb_d;
      n_q       <= n_d;
      mac_vld_q <= mac_vld_d;
      mac_n_q   <= mac_n_d;
      err_q     <= err_d;
      for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START && start_ok) state_d = S_RUN;
      S_RUN:   if (last_n) state_d = S_DRAIN;
      S_DRAIN: state_d = S_WRITE;
      S_WRITE: state_d = (last_tb && last_m) ? S_DONE : S_RUN;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data arrives one cycle after issue, so the MAC uses the registered n.
  always_comb begin
    w_sel = RDATA_W[(int'(mac_n_q) % LANES)*DW +: DW];
    for (int l = 0; l < LANES; l++) begin
      i_el[l]   = RDATA_I[l*DW +: DW];
      prod_s[l] = $signed({{DW{w_sel[DW-1]}}, w_sel}) * $signed({{DW{i_el[l][DW-1]}}, i_el[l]});
      prod_u[l] = {{DW{1'b0}}, w_sel} * {{DW{1'b0}}, i_el[l]};
      prod[l]   = sgn_q ? {{(ACC_W-2*DW){prod_s[l][2*DW-1]}}, prod_s[l]}
                        : {{(ACC_W-2*DW){1'b0}}, prod_u[l]};
    end
  end

  always_comb begin
    m_dim_d   = m_dim_q;
    n_dim_d   = n_dim_q;
    t_dim_d   = t_dim_q;
    sgn_d     = sgn_q;
    sat_d     = sat_q;
    m_d       = m_q;
    tb_d      = tb_q;
    n_d       = n_q;
    mac_vld_d = (state_q == S_RUN);
    mac_n_d   = n_q;
    err_d     = (state_q == S_IDLE) && START && !start_ok;
    for (int l = 0; l < LANES; l++) acc_d[l] = acc_q[l];
    case (state_q)
      S_IDLE: begin
        if (START && start_ok) begin
          m_dim_d = req_m;
          n_dim_d = req_n;
          t_dim_d = req_t;
          sgn_d   = SIGNED;
          sat_d   = SAT;
          m_d     = '0;
          tb_d    = '0;
          n_d     = '0;
        end
      end
      S_RUN: n_d = last_n ? '0 : n_q + DIM_W'(1);
      S_WRITE: begin
        if (last_tb) begin
          tb_d = '0;
          m_d  = last_m ? '0 : m_q + DIM_W'(1);
        end else begin
          tb_d = tb_q + DIM_W'(1);
        end
      end
      default: ;
    endcase
    if (mac_vld_q) begin
      for (int l = 0; l < LANES; l++)
        acc_d[l] = ((mac_n_q == '0) ? '0 : acc_q[l]) + prod[l];
    end
  end

  // Columns past T are padded with zero in the written word.
  always_comb begin
    wdata = '0;
    for (int l = 0; l < LANES; l++) begin
      if (int'(tb_q) * LANES + l < int'(t_dim_q))
        wdata[l*DW +: DW] = sat_fn(acc_q[l], sgn_q, sat_q);
    end
  end

  always_comb begin
    BUSY    = (state_q != S_IDLE);
    DONE    = (state_q == S_DONE);
    ERR     = err_q;
    EN_I    = (state_q == S_RUN);
    EN_W    = (state_q == S_RUN);
    EN_O    = (state_q == S_WRITE);
    RW_O    = (state_q == S_WRITE);
    ADDR_I  = AW'(int'(n_q) * TB_MAX + int'(tb_q));
    ADDR_W  = AW'(int'(m_q) * TB_MAX + int'(n_q) / LANES);
    ADDR_O  = AW'(int'(m_q) * TB_MAX + int'(tb_q));
    WDATA_O = (state_q == S_WRITE) ? wdata : '0;
  end
endmodule
